// File: rtl/scratch_stack_ctrl_pkg.sv
// Shared definitions for the scratch stack sequencer: command opcodes and
// controller state encodings.
package scratch_stack_ctrl_pkg;

  // Command opcodes as presented on cmd_op.
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_FIN     = 3'd4
  } state_e;

endpackage

// File: rtl/scratch_stack_ctrl_sram.sv
// Single-port synchronous stack RAM with registered read. Contents are never
// reset so the array maps onto block RAM.
module scratch_stack_ctrl_sram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Write on wen; read data lands one cycle after the address is sampled.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/scratch_stack_ctrl.sv
// Scratch stack sequencer: owns TOS, stack pointer and the stack RAM, and
// serialises PUSH/POP/REPLACE/NOP commands from a valid/ready port.
// Optional build macro STACK_GUARD_EN: PUSH when full / POP when empty become
// no-ops that set a sticky err flag. Without it the pointer simply wraps.
module scratch_stack_ctrl
  import scratch_stack_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              done,
  output logic [DATA_W-1:0] tos,
  output logic [ADDR_W:0]   depth,
  output logic              empty,
  output logic              full,
  output logic              err
);

  // Depth value meaning every RAM entry is occupied.
  localparam logic [ADDR_W:0] DEPTH_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_reg, state_next;
  logic [DATA_W-1:0] tos_reg, tos_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [ADDR_W-1:0] sp_reg, sp_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W:0]   depth_reg, depth_next;
  logic              err_reg, err_next;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_rdata;
  logic              push_blocked;
  logic              pop_blocked;
  op_e               op;

  assign op    = op_e'(cmd_op);
  assign tos   = tos_reg;
  assign depth = depth_reg;
  assign empty = (depth_reg == '0);
  assign full  = (depth_reg == DEPTH_FULL);

`ifdef STACK_GUARD_EN
  assign push_blocked = full;
  assign pop_blocked  = empty;
  assign err          = err_reg;
`else
  assign push_blocked = 1'b0;
  assign pop_blocked  = 1'b0;
  assign err          = 1'b0;
`endif

  scratch_stack_ctrl_sram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk  (CLK),
    .wen  (ram_wen),
    .addr (addr_reg),
    .wdata(wdata_reg),
    .rdata(ram_rdata)
  );

  // Next-state, datapath updates and handshake outputs for the sequencer.
  always_comb begin
    state_next = state_reg;
    tos_next   = tos_reg;
    wdata_next = wdata_reg;
    sp_next    = sp_reg;
    addr_next  = addr_reg;
    depth_next = depth_reg;
    err_next   = err_reg;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    ram_wen    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (op)
            OP_NOP: begin
              state_next = ST_FIN;
            end
            OP_REPLACE: begin
              tos_next   = cmd_data;
              state_next = ST_FIN;
            end
            OP_PUSH: begin
              if (push_blocked) begin
                err_next   = 1'b1;
                state_next = ST_FIN;
              end else begin
                // Old TOS spills into RAM; the new value becomes TOS at once.
                wdata_next = tos_reg;
                addr_next  = sp_reg;
                sp_next    = sp_reg + ADDR_W'(1);
                depth_next = depth_reg + (ADDR_W+1)'(1);
                tos_next   = cmd_data;
                state_next = ST_WRITE;
              end
            end
            default: begin
              if (pop_blocked) begin
                err_next   = 1'b1;
                state_next = ST_FIN;
              end else begin
                addr_next  = sp_reg - ADDR_W'(1);
                sp_next    = sp_reg - ADDR_W'(1);
                depth_next = depth_reg - (ADDR_W+1)'(1);
                state_next = ST_RD_ADDR;
              end
            end
          endcase
        end
      end
      ST_WRITE: begin
        // Reset in this cycle must suppress the spill write.
        ram_wen    = !RST;
        state_next = ST_FIN;
      end
      ST_RD_ADDR: begin
        state_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        tos_next   = ram_rdata;
        state_next = ST_FIN;
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // TOS, pointer, depth, error flag and RAM write staging registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tos_reg   <= '0;
      wdata_reg <= '0;
      sp_reg    <= '0;
      addr_reg  <= '0;
      depth_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      tos_reg   <= tos_next;
      wdata_reg <= wdata_next;
      sp_reg    <= sp_next;
      addr_reg  <= addr_next;
      depth_reg <= depth_next;
      err_reg   <= err_next;
    end
  end

endmodule

// File: tb/tb_scratch_stack_ctrl.sv
// Self-checking bench for scratch_stack_ctrl (ADDR_W=2 so wrap and full are
// reachable). A plain array/counter model of the stack predicts TOS, depth,
// flags and latency. Honours STACK_GUARD_EN the same way the design does.
module tb_scratch_stack_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 2;
  localparam int NENT = 4;   // RAM entries
  localparam int DMOD = 8;   // depth counter modulus

  localparam logic [1:0] C_NOP  = 2'b00;
  localparam logic [1:0] C_PUSH = 2'b01;
  localparam logic [1:0] C_POP  = 2'b10;
  localparam logic [1:0] C_REP  = 2'b11;

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_ready;
  logic          done;
  logic [DW-1:0] tos;
  logic [AW:0]   depth;
  logic          empty;
  logic          full;
  logic          err;

  always #5 clk = ~clk;

  scratch_stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK      (clk),
    .RST      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .done     (done),
    .tos      (tos),
    .depth    (depth),
    .empty    (empty),
    .full     (full),
    .err      (err)
  );

  int total = 0;
  int bad   = 0;

  // Reference stack: RAM image, pointer, depth, TOS and error flag.
  logic [DW-1:0] m_mem [NENT];
  int            m_sp;
  int            m_depth;
  logic [DW-1:0] m_tos;
  logic          m_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one accepted command to the model; returns expected accept->done cycles.
  task automatic model_apply(input logic [1:0] op, input logic [DW-1:0] d, output int lat);
    case (op)
      C_NOP: lat = 1;
      C_REP: begin
        m_tos = d;
        lat   = 1;
      end
      C_PUSH: begin
        if (GUARD && m_depth == NENT) begin
          m_err = 1'b1;
          lat   = 1;
        end else begin
          m_mem[m_sp] = m_tos;
          m_sp        = (m_sp + 1) % NENT;
          m_depth     = (m_depth + 1) % DMOD;
          m_tos       = d;
          lat         = 2;
        end
      end
      default: begin
        if (GUARD && m_depth == 0) begin
          m_err = 1'b1;
          lat   = 1;
        end else begin
          m_sp    = (m_sp + NENT - 1) % NENT;
          m_depth = (m_depth + DMOD - 1) % DMOD;
          m_tos   = m_mem[m_sp];
          lat     = 3;
        end
      end
    endcase
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_tos"},   64'(tos),   64'(m_tos));
    chk({tag, "_depth"}, 64'(depth), 64'(m_depth));
    chk({tag, "_empty"}, 64'(empty), 64'(m_depth == 0));
    chk({tag, "_full"},  64'(full),  64'(m_depth == NENT));
    chk({tag, "_err"},   64'(err),   64'(m_err));
  endtask

  task automatic model_reset();
    m_sp    = 0;
    m_depth = 0;
    m_tos   = '0;
    m_err   = 1'b0;
  endtask

  // Returns at a negedge with the design idle.
  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    chk("rst_done",  64'(done),      64'(0));
    check_state("rst");
  endtask

  // Called at a negedge; waits (bounded) until cmd_ready is seen.
  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(n < 8), 64'(1));
  endtask

  // Issue one command, check latency and resulting state, return at idle negedge.
  task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] d);
    int lat;
    int exp_lat;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_data  = $urandom;
    model_apply(op, d, exp_lat);
    lat = 1;
    @(negedge clk);
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("ready_in_fin", 64'(cmd_ready), 64'(0));
    check_state("op");
    $display("op=%0d data=%08h tos=%08h depth=%0d err=%0b lat=%0d", op, d, tos, depth, err, lat);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'(0));
    chk("idle_ready", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int last;
    int lat;

    for (int i = 0; i < NENT; i++) m_mem[i] = '0;
    model_reset();

    // Bring every RAM entry to a known value.
    do_reset();
    for (int i = 0; i < NENT; i++) do_cmd(C_PUSH, 32'hC0DE_0000 + 32'(i));

    // Basic push/pop ordering.
    do_reset();
    do_cmd(C_PUSH, 32'h11);
    do_cmd(C_PUSH, 32'h22);
    do_cmd(C_PUSH, 32'h33);
    chk("t1_tos_after_push", 64'(tos), 64'h33);
    do_cmd(C_POP, '0);
    do_cmd(C_POP, '0);
    do_cmd(C_POP, '0);
    chk("t1_tos_final", 64'(tos), 64'h0);
    chk("t1_empty_final", 64'(empty), 64'(1));
    do_cmd(C_REP, 32'h5A5A_5A5A);
    do_cmd(C_NOP, 32'hFFFF_FFFF);

    // Held cmd_valid: one accept every three cycles, nothing queued.
    do_reset();
    cmd_valid = 1'b1;
    cmd_op    = C_PUSH;
    accepts   = 0;
    last      = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (cmd_ready) begin
        accepts++;
        if (accepts > 1) chk("t3_spacing", 64'(c - last), 64'(3));
        last     = c;
        cmd_data = 32'h100 + 32'(c);
        model_apply(C_PUSH, cmd_data, lat);
      end
    end
    cmd_valid = 1'b0;
    chk("t3_accepts", 64'(accepts), 64'(4));
    @(negedge clk);
    check_state("t3");
    chk("t3_depth4", 64'(depth), 64'(4));

    // Full boundary, then one more push and the pops that follow.
    do_reset();
    for (int i = 1; i <= 4; i++) do_cmd(C_PUSH, 32'hA0 + 32'(i));
    chk("t4_full", 64'(full), 64'(1));
    do_cmd(C_PUSH, 32'hA5);
    chk("t4_err", 64'(err), 64'(GUARD));
    for (int i = 0; i < 4; i++) do_cmd(C_POP, '0);

    // Pop at empty.
    do_reset();
    do_cmd(C_POP, '0);
    chk("t5_pop_empty_err", 64'(err), 64'(GUARD));

    // Reset during the WRITE cycle of a push must drop the spill write.
    do_reset();
    do_cmd(C_PUSH, 32'h61);
    do_cmd(C_PUSH, 32'h62);
    do_cmd(C_PUSH, 32'h63);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = C_PUSH;
    cmd_data  = 32'h64;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t6_ready", 64'(cmd_ready), 64'(1));
    check_state("t6");
    do_cmd(C_POP, '0);

    // Randomised traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      do_cmd(2'($urandom_range(0, 3)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
